// File: rtl/pulse_sequencer.sv
// Burst-pulse controller: DELAY, then alternating HIGH/LOW phases, all timed in TICK strobes.
// A START in IDLE latches the configuration, so CFG_* changes made mid-burst do not take effect.
module pulse_sequencer #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             CLOCK_50MHZ,
    input  logic             RESET_N,
    input  logic             TICK,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] CFG_DELAY,
    input  logic [CNT_W-1:0] CFG_HIGH,
    input  logic [CNT_W-1:0] CFG_LOW,
    input  logic [NUM_W-1:0] CFG_COUNT,
    output logic             PULSE_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [NUM_W-1:0] PULSE_CNT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [NUM_W-1:0] count_q, count_d;
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             phase_exit;
    logic [NUM_W-1:0] pulse_cnt_inc;

    // A zero high/low duration still occupies one tick.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign phase_exit    = TICK && (timer_q <= CNT_W'(1));
    assign pulse_cnt_inc = pulse_cnt_q + NUM_W'(1);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        high_d      = high_q;
        low_d       = low_q;
        count_d     = count_q;
        pulse_cnt_d = pulse_cnt_q;
        done_d      = 1'b0;

        if (state_q == S_IDLE) begin
            if (START && !ABORT) begin
                high_d      = CFG_HIGH;
                low_d       = CFG_LOW;
                count_d     = CFG_COUNT;
                pulse_cnt_d = '0;
                if (CFG_DELAY == '0) begin
                    state_d = S_HIGH;
                    timer_d = at_least_one(CFG_HIGH);
                end else begin
                    state_d = S_DELAY;
                    timer_d = CFG_DELAY;
                end
            end
        end else if (ABORT) begin
            state_d = S_IDLE;
        end else if (TICK && !phase_exit) begin
            timer_d = timer_q - CNT_W'(1);
        end else if (phase_exit) begin
            case (state_q)
                S_DELAY, S_LOW: begin
                    state_d = S_HIGH;
                    timer_d = at_least_one(high_q);
                end
                S_HIGH: begin
                    pulse_cnt_d = pulse_cnt_inc;
                    // Count reached: finish on the falling edge, no trailing low phase.
                    if (count_q != '0 && pulse_cnt_inc == count_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOW;
                        timer_d = at_least_one(low_q);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pulse_d = (state_d == S_HIGH);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            high_q      <= '0;
            low_q       <= '0;
            count_q     <= '0;
            pulse_cnt_q <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            high_q      <= high_d;
            low_q       <= low_d;
            count_q     <= count_d;
            pulse_cnt_q <= pulse_cnt_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign PULSE_OUT = pulse_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PULSE_CNT = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: per-scenario tasks with hand-derived expected waveforms.
module tb_pulse_sequencer;

    localparam int CNT_W = 16;
    localparam int NUM_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick, start, abort;
    logic [CNT_W-1:0] cfg_delay, cfg_high, cfg_low;
    logic [NUM_W-1:0] cfg_count;
    logic             pulse_out, busy, done;
    logic [NUM_W-1:0] pulse_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    pulse_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .CLOCK_50MHZ(clk),
        .RESET_N    (rst_n),
        .TICK       (tick),
        .START      (start),
        .ABORT      (abort),
        .CFG_DELAY  (cfg_delay),
        .CFG_HIGH   (cfg_high),
        .CFG_LOW    (cfg_low),
        .CFG_COUNT  (cfg_count),
        .PULSE_OUT  (pulse_out),
        .BUSY       (busy),
        .DONE       (done),
        .PULSE_CNT  (pulse_cnt)
    );

    // Advance one clock; return at the following falling edge, where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_cfg(input int d, input int h, input int l, input int c);
        cfg_delay = CNT_W'(d);
        cfg_high  = CNT_W'(h);
        cfg_low   = CNT_W'(l);
        cfg_count = NUM_W'(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0;
        load_cfg(0, 0, 0, 0);
        step(); step();
        vectors++;
        if ({pulse_out, busy, done, pulse_cnt} !== {3'b000, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got p=%b b=%b d=%b cnt=%0d, want all 0", pulse_out, busy, done, pulse_cnt);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got p=%b b=%b d=%b, want 000", pulse_out, busy, done);
        end
    endtask

    task automatic test_tick_held();
        // Expected PULSE_OUT after each edge following the START edge (index 0 = START edge).
        logic exp_p [0:8] = '{0, 0, 1, 1, 1, 0, 1, 1, 1};
        tick = 1'b1;
        load_cfg(2, 3, 1, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (pulse_out !== exp_p[i] || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL tick_held_wave[%0d]: got p=%b b=%b d=%b, want p=%b b=1 d=0", i, pulse_out, busy, done, exp_p[i]);
            end
            step();
        end
        vectors++;
        if ({pulse_out, busy, done, pulse_cnt} !== {3'b001, 8'd2}) begin
            miscompares++;
            $display("FAIL tick_held_done: got p=%b b=%b d=%b cnt=%0d, want p=0 b=0 d=1 cnt=2", pulse_out, busy, done, pulse_cnt);
        end
        step();
        vectors++;
        if (done !== 1'b0 || pulse_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL tick_held_done_clear: got d=%b cnt=%0d, want d=0 cnt=2", done, pulse_cnt);
        end
    endtask

    task automatic test_slow_tick();
        int busy_cycles = 1;
        int rises = 1;
        int dones = 0;
        logic prev_p;
        tick = 1'b0;
        load_cfg(0, 0, 0, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (pulse_out !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL slow_first_rise: got p=%b b=%b, want p=1 b=1", pulse_out, busy);
        end
        prev_p = pulse_out;
        for (int i = 1; i <= 300; i++) begin
            tick = (i % 50 == 0);
            step();
            if (busy) busy_cycles++;
            if (done) dones++;
            if (pulse_out && !prev_p) rises++;
            prev_p = pulse_out;
        end
        tick = 1'b0;
        vectors++;
        if (busy_cycles != 250) begin
            miscompares++;
            $display("FAIL slow_busy_time: got %0d cycles, want 250", busy_cycles);
        end
        vectors++;
        if (rises != 3 || dones != 1 || pulse_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL slow_counts: got rises=%0d dones=%0d cnt=%0d, want 3 1 3", rises, dones, pulse_cnt);
        end
    endtask

    task automatic test_continuous();
        int falls = 0;
        int dones = 0;
        logic prev_p;
        tick = 1'b1;
        load_cfg(0, 1, 1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        prev_p = pulse_out;
        for (int i = 1; i <= 599; i++) begin
            step();
            if (prev_p && !pulse_out) falls++;
            if (done) dones++;
            prev_p = pulse_out;
        end
        vectors++;
        if (falls != 300 || pulse_cnt !== 8'd44 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL cont_wrap: got pulses=%0d cnt=%0d b=%b, want 300 44 1", falls, pulse_cnt, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({pulse_out, busy, done, pulse_cnt} !== {3'b000, 8'd44} || dones != 0) begin
            miscompares++;
            $display("FAIL cont_abort: got p=%b b=%b d=%b cnt=%0d dones=%0d, want 0 0 0 44 0", pulse_out, busy, done, pulse_cnt, dones);
        end
    endtask

    task automatic test_shadow();
        int run = 1;
        int busy_cycles = 1;
        int widths_bad = 0;
        int falls = 0;
        logic prev_p;
        tick = 1'b1;
        load_cfg(0, 4, 2, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        prev_p = pulse_out;
        for (int i = 1; i <= 30; i++) begin
            if (i == 2) cfg_high = CNT_W'(9);
            start = (i == 3 || i == 8);
            step();
            if (busy) busy_cycles++;
            if (pulse_out) run++;
            if (prev_p && !pulse_out) begin
                falls++;
                if (run != 4) widths_bad++;
                run = 0;
            end
            prev_p = pulse_out;
        end
        start = 1'b0;
        vectors++;
        if (widths_bad != 0 || falls != 3) begin
            miscompares++;
            $display("FAIL shadow_widths: got bad=%0d pulses=%0d, want 0 3", widths_bad, falls);
        end
        vectors++;
        if (busy_cycles != 16) begin
            miscompares++;
            $display("FAIL shadow_no_restart: got busy=%0d cycles, want 16", busy_cycles);
        end
    endtask

    task automatic test_abort_start_idle();
        load_cfg(0, 2, 2, 1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if ({pulse_out, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_blocks_start: got p=%b b=%b d=%b, want 000", pulse_out, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        tick = 1'b1;
        load_cfg(0, 1, 1, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        vectors++;
        if ({done, busy, pulse_cnt} !== {2'b10, 8'd1}) begin
            miscompares++;
            $display("FAIL b2b_first_done: got d=%b b=%b cnt=%0d, want d=1 b=0 cnt=1", done, busy, pulse_cnt);
        end
        load_cfg(1, 2, 1, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if ({busy, pulse_out, done, pulse_cnt} !== {3'b100, 8'd0}) begin
            miscompares++;
            $display("FAIL b2b_restart: got b=%b p=%b d=%b cnt=%0d, want b=1 p=0 d=0 cnt=0", busy, pulse_out, done, pulse_cnt);
        end
        step();
        vectors++;
        if (pulse_out !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_delay_one: got p=%b, want 1", pulse_out);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_reset_mid_burst();
        tick = 1'b1;
        load_cfg(0, 5, 1, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        vectors++;
        if (pulse_out !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre: got p=%b, want 1", pulse_out);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pulse_out, busy, done, pulse_cnt} !== {3'b000, 8'd0}) begin
            miscompares++;
            $display("FAIL rst_mid_async: got p=%b b=%b d=%b cnt=%0d, want all 0", pulse_out, busy, done, pulse_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
        load_cfg(0, 3, 1, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if ({pulse_out, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_restart: got p=%b b=%b, want 11", pulse_out, busy);
        end
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if ({pulse_out, busy, done, pulse_cnt} !== {3'b001, 8'd1}) begin
            miscompares++;
            $display("FAIL rst_restart_done: got p=%b b=%b d=%b cnt=%0d, want 0 0 1 1", pulse_out, busy, done, pulse_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_tick_held();
        test_slow_tick();
        test_continuous();
        test_shadow();
        test_abort_start_idle();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Programmable burst-pulse controller for the pulse generator. On a START request it latches a delay/high/low/count configuration and drives PULSE_OUT through delay, high and low phases. All durations are counted in TICK strobes, the single-cycle time-base enable produced alongside the clock divider (e.g. 1 µs). It sits between the user/config registers and the output pin, and owns sequencing, abort and completion signalling.

## Interface
- CNT_W, 16: width of delay/high/low tick counts
- NUM_W, 8: width of pulse count and completed-pulse counter

- CLOCK_50MHZ  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- TICK  in  1  single-cycle time-base strobe; may be held high (one tick per clock)
- START  in  1  burst request; sampled only in IDLE
- ABORT  in  1  terminate burst; priority over START and TICK
- CFG_DELAY  in  CNT_W  ticks from start to first rising edge; 0 = no delay
- CFG_HIGH  in  CNT_W  ticks per high phase; 0 treated as 1
- CFG_LOW  in  CNT_W  ticks per low phase between pulses; 0 treated as 1
- CFG_COUNT  in  NUM_W  pulses per burst; 0 = continuous until ABORT
- PULSE_OUT  out  1  registered pulse output
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle strobe on normal burst completion
- PULSE_CNT  out  NUM_W  pulses completed in current/last burst

## Operation
- States: IDLE, DELAY, HIGH, LOW. PULSE_OUT = 1 exactly when state is HIGH. All outputs are registered.
- IDLE + START (no ABORT): latch the CFG_* inputs into shadow registers, clear PULSE_CNT. Go to DELAY with timer = CFG_DELAY. If CFG_DELAY = 0, go to HIGH with timer = max(CFG_HIGH, 1).
- CFG_* changes while BUSY have no effect on the running burst.
- Timer rule in DELAY/HIGH/LOW: on TICK, if timer = 1, take the phase exit; otherwise decrement. With no TICK, the timer holds. Each phase therefore lasts exactly N TICK strobes.
- DELAY exit: go to HIGH, timer = max(CFG_HIGH, 1).
- HIGH exit: PULSE_CNT += 1.
  - If CFG_COUNT ≠ 0 and the new PULSE_CNT = CFG_COUNT: go to IDLE and assert DONE for one cycle. No trailing LOW phase.
  - Otherwise go to LOW, timer = max(CFG_LOW, 1).
- LOW exit: go to HIGH, timer = max(CFG_HIGH, 1).
- Continuous mode (CFG_COUNT = 0): PULSE_CNT wraps modulo 2^NUM_W. The burst never self-terminates.
- ABORT in any non-IDLE state: go to IDLE next cycle; PULSE_OUT = 0, DONE stays 0, PULSE_CNT holds its value.
- ABORT in IDLE: no effect, and it blocks a simultaneous START.
- START while BUSY is ignored. It is not queued.
- RESET_N low: immediately force IDLE. PULSE_OUT = 0, BUSY = 0, DONE = 0, PULSE_CNT = 0, timer and shadow registers = 0. This applies mid-burst too.

## Timing
- START accepted at edge t: BUSY = 1 from t+1.
- CFG_DELAY = 0: PULSE_OUT = 1 from t+1.
- CFG_DELAY = D > 0: PULSE_OUT rises the cycle after the D-th TICK following t.
- Each high phase lasts CFG_HIGH TICKs; each low phase lasts CFG_LOW TICKs.
- Completion: on the cycle after the final HIGH exit, PULSE_OUT → 0, BUSY → 0 and DONE = 1, all in the same cycle. DONE clears the following cycle.
- Back-to-back bursts: a new START can be accepted on the cycle DONE is high, because the state is already IDLE.
- TICK held high: durations equal clock cycles, so HIGH = 3 gives 3 cycles of PULSE_OUT.
- ABORT sampled at edge t: PULSE_OUT, BUSY = 0 at t+1.

## Test plan
- Reset mid-burst: deassert RESET_N while PULSE_OUT = 1 → PULSE_OUT, BUSY, DONE, PULSE_CNT = 0 immediately. START after release behaves normally.
- TICK = 1 constant; DELAY = 2, HIGH = 3, LOW = 1, COUNT = 2 → after START: 2 cycles low, 3 high, 1 low, 3 high. Then DONE for 1 cycle, BUSY falls, PULSE_CNT = 2.
- TICK every 50 cycles; DELAY = 0, HIGH = 0, LOW = 0, COUNT = 3 → first rise 1 cycle after START. Each phase is 1 tick (50 cycles): 3 pulses, DONE once, total BUSY time 250 cycles.
- Continuous: COUNT = 0, HIGH = LOW = 1, TICK = 1, NUM_W = 8 → 300 pulses emitted, PULSE_CNT = 44 (wrapped). Then ABORT → PULSE_OUT = 0 and BUSY = 0 next cycle, DONE never asserted.
- Config shadowing and ignored START: change CFG_HIGH from 4 to 9 and pulse START during the burst → all pulses keep width 4 and no restart occurs.
- START with ABORT in the same IDLE cycle → stays IDLE, BUSY = 0. START on the DONE cycle → new burst begins, BUSY = 1 next cycle.
